// File: rtl/id_int_seq.sv
// Interrupt entry/return sequencer: edge-detected request channels, fixed priority, PC-stack handshake.
// Optional build macro ID_INT_NEST_EN enables priority nesting of interrupt service levels.
module id_int_seq #(
    parameter int          I_WIDTH   = 16,
    parameter int          ADR_WIDTH = 8,
    parameter int          N_INT     = 4,
    parameter int unsigned VEC_BASE  = 32'hF0,
    parameter int unsigned VEC_STEP  = 2,
    parameter int unsigned ADR_BLAD  = 32'hFC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_INT-1:0]     int_req,
    input  logic [I_WIDTH-1:0]   rozkaz,
    input  logic                 rozkaz_valid,
    output logic                 rozkaz_ready,
    input  logic                 stos_pc_full,
    input  logic                 stos_pc_empty,
    output logic                 skok,
    output logic                 push_pc,
    output logic                 pop_pc,
    output logic                 skok_pc,
    output logic [ADR_WIDTH-1:0] adres_skok,
    output logic                 int_en_stan,
    output logic [N_INT-1:0]     int_pending,
    output logic [N_INT-1:0]     int_aktywne,
    output logic                 blad_stosu
);

    localparam int K_W = (N_INT > 1) ? $clog2(N_INT) : 1;
    localparam logic [4:0] OP_SEI  = 5'b11000;
    localparam logic [4:0] OP_CLI  = 5'b11001;
    localparam logic [4:0] OP_RETI = 5'b11010;
    localparam logic [ADR_WIDTH-1:0] BLAD_ADR = ADR_WIDTH'(ADR_BLAD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WEJSCIE = 2'd1,
        SKOK    = 2'd2
    } state_t;

    state_t           state;
    logic [K_W-1:0]   k_q;
    logic [N_INT-1:0] req_q;

    logic [N_INT-1:0]     edge_det;
    logic                 pend_any;
    logic [K_W-1:0]       pend_idx;
    logic                 qualify;
    logic                 entry;
    logic                 accept;
    logic [4:0]           opcode;
    logic                 is_sei;
    logic                 is_cli;
    logic                 is_reti;
    logic                 reti_ok;
    logic [N_INT-1:0]     akt_low;
    logic [N_INT-1:0]     k_onehot;
    logic [N_INT-1:0]     pend_clr;
    logic [ADR_WIDTH-1:0] vec_adr;
    logic                 unused_rozkaz;

    assign unused_rozkaz = ^rozkaz[I_WIDTH-6:0];

    assign edge_det = int_req & ~req_q;

    // Lowest index wins: scan downward so the last hit is the highest priority.
    always_comb begin
        pend_any = 1'b0;
        pend_idx = '0;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (int_pending[i]) begin
                pend_any = 1'b1;
                pend_idx = K_W'(i);
            end
        end
    end

`ifdef ID_INT_NEST_EN
    logic [N_INT-1:0] le_mask;

    always_comb begin
        le_mask = '0;
        for (int i = 0; i < N_INT; i++) begin
            le_mask[i] = (i <= int'(pend_idx));
        end
    end

    assign qualify = ~|(int_aktywne & le_mask);
`else
    assign qualify = ~|int_aktywne;
`endif

    assign entry        = (state == IDLE) && int_en_stan && pend_any && qualify;
    // Gating with rst_n keeps the same-cycle RETI outputs quiet while reset is held.
    assign rozkaz_ready = rst_n && (state == IDLE) && !entry;
    assign accept       = rozkaz_valid && rozkaz_ready;

    assign opcode  = rozkaz[I_WIDTH-1 -: 5];
    assign is_sei  = (opcode == OP_SEI);
    assign is_cli  = (opcode == OP_CLI);
    assign is_reti = (opcode == OP_RETI);
    assign reti_ok = (|int_aktywne) && !stos_pc_empty;

    assign akt_low  = int_aktywne & (~int_aktywne + N_INT'(1));
    assign k_onehot = N_INT'(1) << k_q;
    assign pend_clr = (state == SKOK) ? k_onehot : '0;
    assign vec_adr  = ADR_WIDTH'(VEC_BASE + 32'(k_q) * VEC_STEP);

    always_comb begin
        skok       = 1'b0;
        push_pc    = 1'b0;
        pop_pc     = 1'b0;
        skok_pc    = 1'b0;
        blad_stosu = 1'b0;
        adres_skok = '0;
        case (state)
            IDLE: begin
                if (accept && is_reti) begin
                    if (reti_ok) begin
                        pop_pc  = 1'b1;
                        skok    = 1'b1;
                        skok_pc = 1'b1;
                    end else begin
                        skok       = 1'b1;
                        adres_skok = BLAD_ADR;
                        blad_stosu = 1'b1;
                    end
                end
            end
            WEJSCIE: begin
                if (!stos_pc_full) begin
                    push_pc = 1'b1;
                end else begin
                    skok       = 1'b1;
                    adres_skok = BLAD_ADR;
                    blad_stosu = 1'b1;
                end
            end
            SKOK: begin
                skok       = 1'b1;
                adres_skok = vec_adr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k_q         <= '0;
            req_q       <= '0;
            int_pending <= '0;
            int_aktywne <= '0;
            int_en_stan <= 1'b0;
        end else begin
            req_q       <= int_req;
            // A new edge on the bit being serviced survives the clear.
            int_pending <= (int_pending & ~pend_clr) | edge_det;
            case (state)
                IDLE: begin
                    if (entry) begin
                        state <= WEJSCIE;
                        k_q   <= pend_idx;
                    end else if (accept) begin
                        if (is_sei) begin
                            int_en_stan <= 1'b1;
                        end
                        if (is_cli) begin
                            int_en_stan <= 1'b0;
                        end
                        if (is_reti && reti_ok) begin
                            int_aktywne <= int_aktywne & ~akt_low;
                            int_en_stan <= 1'b1;
                        end
                    end
                end
                WEJSCIE: begin
                    if (stos_pc_full) begin
                        int_en_stan <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= SKOK;
                    end
                end
                SKOK: begin
                    int_aktywne <= int_aktywne | k_onehot;
                    int_en_stan <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_int_seq.sv
// Directed bench for id_int_seq: entry, priority, nesting, stack errors, RETI and async reset.
module tb_id_int_seq;

    logic        clk;
    logic        rst_n;
    logic [3:0]  int_req;
    logic [15:0] rozkaz;
    logic        rozkaz_valid;
    logic        rozkaz_ready;
    logic        stos_pc_full;
    logic        stos_pc_empty;
    logic        skok;
    logic        push_pc;
    logic        pop_pc;
    logic        skok_pc;
    logic [7:0]  adres_skok;
    logic        int_en_stan;
    logic [3:0]  int_pending;
    logic [3:0]  int_aktywne;
    logic        blad_stosu;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] SEI  = 16'hC000;
    localparam logic [15:0] CLI  = 16'hC800;
    localparam logic [15:0] RETI = 16'hD000;
    localparam logic [15:0] NOP  = 16'h0000;

    id_int_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_req      (int_req),
        .rozkaz       (rozkaz),
        .rozkaz_valid (rozkaz_valid),
        .rozkaz_ready (rozkaz_ready),
        .stos_pc_full (stos_pc_full),
        .stos_pc_empty(stos_pc_empty),
        .skok         (skok),
        .push_pc      (push_pc),
        .pop_pc       (pop_pc),
        .skok_pc      (skok_pc),
        .adres_skok   (adres_skok),
        .int_en_stan  (int_en_stan),
        .int_pending  (int_pending),
        .int_aktywne  (int_aktywne),
        .blad_stosu   (blad_stosu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Called in the IDLE cycle where entry has been decided.
    task automatic expect_entry(input string tag, input logic [7:0] vec, input logic [3:0] akt);
        tick();
        check({tag, "_push"}, 32'(push_pc), 32'd1);
        check({tag, "_wskok"}, 32'(skok), 32'd0);
        tick();
        check({tag, "_skok"}, 32'(skok), 32'd1);
        check({tag, "_vec"}, 32'(adres_skok), 32'(vec));
        check({tag, "_spush"}, 32'(push_pc), 32'd0);
        tick();
        check({tag, "_akt"}, 32'(int_aktywne), 32'(akt));
        check({tag, "_en"}, 32'(int_en_stan), 32'd0);
    endtask

    task automatic reti_ok(input string tag, input logic [3:0] akt_after);
        rozkaz        = RETI;
        rozkaz_valid  = 1'b1;
        stos_pc_empty = 1'b0;
        #1;
        check({tag, "_pop"}, 32'(pop_pc), 32'd1);
        check({tag, "_skokpc"}, 32'(skok_pc), 32'd1);
        check({tag, "_skok"}, 32'(skok), 32'd1);
        check({tag, "_blad"}, 32'(blad_stosu), 32'd0);
        tick();
        rozkaz_valid = 1'b0;
        check({tag, "_akt"}, 32'(int_aktywne), 32'(akt_after));
        check({tag, "_en"}, 32'(int_en_stan), 32'd1);
    endtask

    task automatic send(input logic [15:0] instr);
        rozkaz       = instr;
        rozkaz_valid = 1'b1;
        tick();
        rozkaz_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        int_req       = 4'b0000;
        rozkaz        = RETI;
        rozkaz_valid  = 1'b1;
        stos_pc_full  = 1'b0;
        stos_pc_empty = 1'b0;
        #2;
        check("rst_ready", 32'(rozkaz_ready), 32'd0);
        check("rst_pop", 32'(pop_pc), 32'd0);
        check("rst_skok", 32'(skok), 32'd0);
        check("rst_adr", 32'(adres_skok), 32'd0);
        check("rst_blad", 32'(blad_stosu), 32'd0);
        check("rst_pend", 32'(int_pending), 32'd0);
        check("rst_akt", 32'(int_aktywne), 32'd0);
        check("rst_en", 32'(int_en_stan), 32'd0);
        rozkaz_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_ready", 32'(rozkaz_ready), 32'd1);

        // SEI then single pulse on channel 2
        send(SEI);
        check("sei_en", 32'(int_en_stan), 32'd1);
        int_req = 4'b0100;
        tick();
        int_req = 4'b0000;
        check("c2_pend", 32'(int_pending), 32'h4);
        check("c2_ready", 32'(rozkaz_ready), 32'd0);
        expect_entry("c2", 8'hF4, 4'b0100);
        check("c2_pclr", 32'(int_pending), 32'd0);

        // Higher-priority request while channel 2 is in service
        send(SEI);
        int_req = 4'b0001;
        tick();
        int_req = 4'b0000;
        check("nest_pend", 32'(int_pending), 32'h1);
`ifdef ID_INT_NEST_EN
        check("nest_ready", 32'(rozkaz_ready), 32'd0);
        expect_entry("nest", 8'hF0, 4'b0101);
        reti_ok("nest_r0", 4'b0100);
        reti_ok("nest_r2", 4'b0000);
`else
        check("nonest_ready", 32'(rozkaz_ready), 32'd1);
        tick();
        check("nonest_hold", 32'(int_pending), 32'h1);
        reti_ok("nonest_r2", 4'b0000);
        check("nonest_ready2", 32'(rozkaz_ready), 32'd0);
        expect_entry("nonest", 8'hF0, 4'b0001);
        reti_ok("nonest_r0", 4'b0000);
`endif

        // Two requests together: channel 1 first, channel 3 left pending
        int_req = 4'b1010;
        tick();
        int_req = 4'b0000;
        check("pri_pend", 32'(int_pending), 32'hA);
        check("pri_ready", 32'(rozkaz_ready), 32'd0);
        expect_entry("pri1", 8'hF2, 4'b0010);
        check("pri_left", 32'(int_pending), 32'h8);
        reti_ok("pri_r1", 4'b0000);
        check("pri3_ready", 32'(rozkaz_ready), 32'd0);
        expect_entry("pri3", 8'hF6, 4'b1000);
        reti_ok("pri_r3", 4'b0000);

        // Entry with the PC stack full
        stos_pc_full = 1'b1;
        int_req = 4'b0010;
        tick();
        int_req = 4'b0000;
        tick();
        check("full_skok", 32'(skok), 32'd1);
        check("full_adr", 32'(adres_skok), 32'hFC);
        check("full_blad", 32'(blad_stosu), 32'd1);
        check("full_push", 32'(push_pc), 32'd0);
        tick();
        check("full_blad1", 32'(blad_stosu), 32'd0);
        check("full_pend", 32'(int_pending), 32'h2);
        check("full_en", 32'(int_en_stan), 32'd0);
        check("full_akt", 32'(int_aktywne), 32'd0);
        stos_pc_full = 1'b0;

        // Instruction is refused in the cycle an entry is decided
        send(SEI);
        rozkaz       = CLI;
        rozkaz_valid = 1'b1;
        #1;
        check("entry_noacc", 32'(rozkaz_ready), 32'd0);
        rozkaz_valid = 1'b0;
        expect_entry("retry1", 8'hF2, 4'b0010);

        // RETI with an empty stack
        rozkaz        = RETI;
        rozkaz_valid  = 1'b1;
        stos_pc_empty = 1'b1;
        #1;
        check("empty_pop", 32'(pop_pc), 32'd0);
        check("empty_skok", 32'(skok), 32'd1);
        check("empty_adr", 32'(adres_skok), 32'hFC);
        check("empty_blad", 32'(blad_stosu), 32'd1);
        tick();
        rozkaz_valid  = 1'b0;
        stos_pc_empty = 1'b0;
        check("empty_akt", 32'(int_aktywne), 32'h2);
        check("empty_en", 32'(int_en_stan), 32'd0);
        reti_ok("ret_r1", 4'b0000);

        send(CLI);
        check("cli_en", 32'(int_en_stan), 32'd0);

        // RETI with nothing in service
        rozkaz       = RETI;
        rozkaz_valid = 1'b1;
        #1;
        check("noact_adr", 32'(adres_skok), 32'hFC);
        check("noact_blad", 32'(blad_stosu), 32'd1);
        check("noact_pop", 32'(pop_pc), 32'd0);
        check("noact_skokpc", 32'(skok_pc), 32'd0);
        tick();
        rozkaz_valid = 1'b0;
        check("noact_en", 32'(int_en_stan), 32'd0);

        rozkaz       = NOP;
        rozkaz_valid = 1'b1;
        #1;
        check("nop_skok", 32'(skok), 32'd0);
        check("nop_blad", 32'(blad_stosu), 32'd0);
        tick();
        rozkaz_valid = 1'b0;
        check("nop_en", 32'(int_en_stan), 32'd0);

        // Asynchronous reset in the SKOK cycle
        send(SEI);
        int_req = 4'b0100;
        tick();
        int_req = 4'b0000;
        tick();
        check("ar_push", 32'(push_pc), 32'd1);
        tick();
        check("ar_skok", 32'(skok), 32'd1);
        check("ar_vec", 32'(adres_skok), 32'hF4);
        rst_n   = 1'b0;
        int_req = 4'b1000;
        #1;
        check("ar_skok0", 32'(skok), 32'd0);
        check("ar_adr0", 32'(adres_skok), 32'd0);
        check("ar_push0", 32'(push_pc), 32'd0);
        check("ar_pend0", 32'(int_pending), 32'd0);
        check("ar_akt0", 32'(int_aktywne), 32'd0);
        check("ar_en0", 32'(int_en_stan), 32'd0);
        check("ar_ready0", 32'(rozkaz_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_idle", 32'(rozkaz_ready), 32'd1);
        tick();
        check("hi_at_rel", 32'(int_pending), 32'h8);

        // New edge on the channel being cleared keeps it pending
        send(SEI);
        int_req = 4'b0000;
        tick();
        check("sc_push", 32'(push_pc), 32'd1);
        tick();
        int_req = 4'b1000;
        check("sc_vec", 32'(adres_skok), 32'hF6);
        tick();
        check("sc_pend", 32'(int_pending), 32'h8);
        check("sc_akt", 32'(int_aktywne), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
